// File: rtl/regfile_pkg.sv
// Shared types, defaults and the write-port resolver used by the register file
// and its scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]          xlen_t;

  // Returns {hit, index} of the highest-index asserted bit; ports beyond NWR arrive as 0.
  function automatic logic [2:0] wr_match(input logic [3:0] hits);
    logic [2:0] res;
    res = 3'b000;
    for (int j = 0; j < 4; j++) begin
      if (hits[j]) begin
        res = {1'b1, j[1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending bit per architectural register, set on issue,
// cleared on write-back or flush.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NWR-1:0]     wr_en,
  input  logic [NWR*AW-1:0]  wr_addr,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  input  logic               flush,
  output logic [NREGS-1:0]   pending,
  output logic               any_busy
);

  logic [NREGS-1:0] pend_r;
  logic [NREGS-1:0] pend_nxt_s;
  logic             any_busy_r;

  // Next pending state: flush beats everything, issue set beats write-back clear.
  always_comb begin
    pend_nxt_s = pend_r;
    if (flush) begin
      pend_nxt_s = {NREGS{1'b0}};
    end else begin
      for (int j = 0; j < NWR; j++) begin
        pend_nxt_s[wr_addr[j*AW +: AW]] = pend_nxt_s[wr_addr[j*AW +: AW]] & ~wr_en[j];
      end
      pend_nxt_s[iss_rd] = pend_nxt_s[iss_rd] | (iss_valid & (iss_rd != {AW{1'b0}}));
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Pending bits and the drain flag, registered together so any_busy tracks pend_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r     <= {NREGS{1'b0}};
      any_busy_r <= 1'b0;
    end else begin
      pend_r     <= pend_nxt_s;
      any_busy_r <= |pend_nxt_s;
    end
  end

  assign pending  = pend_r;
  assign any_busy = any_busy_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write bypass and an
// integrated busy-bit scoreboard for RAW hazard detection in decode.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic                any_busy
);

  logic [3:0]           wen_s;
  logic [3:0][AW-1:0]   waddr_s;
  logic [3:0][XLEN-1:0] wdata_s;
  logic [XLEN-1:0]      mem_r [NREGS];
  logic [3:0]           whit_s [NREGS];
  logic [2:0]           wsel_s [NREGS];
  logic [NREGS-1:0]     pend_s;

  // Pad the write ports to the resolver's fixed width of four.
  for (genvar j = 0; j < 4; j++) begin : gen_wpad
    if (j < NWR) begin : g_live
      assign wen_s[j]   = wr_en[j];
      assign waddr_s[j] = wr_addr[j*AW +: AW];
      assign wdata_s[j] = wr_data[j*XLEN +: XLEN];
    end else begin : g_tie
      assign wen_s[j]   = 1'b0;
      assign waddr_s[j] = {AW{1'b0}};
      assign wdata_s[j] = {XLEN{1'b0}};
    end
  end

  // Per-register write selection: which port, if any, lands on each entry.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      for (int j = 0; j < 4; j++) begin
        whit_s[i][j] = wen_s[j] && (waddr_s[j] == i[AW-1:0]);
      end
      wsel_s[i] = wr_match(whit_s[i]);
    end
  end

  // Data array; entry 0 is held at zero and optimises away.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      mem_r[0] <= {XLEN{1'b0}};
      for (int i = 1; i < NREGS; i++) begin
        if (wsel_s[i][2]) begin
          mem_r[i] <= wdata_s[wsel_s[i][1:0]];
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
    end
  end

  // Read ports: x0, then youngest same-cycle write, then storage.
  for (genvar k = 0; k < NRD; k++) begin : gen_rd
    logic [AW-1:0]   ra_s;
    logic [3:0]      rhit_s;
    logic [2:0]      rsel_s;
    logic [XLEN-1:0] rdata_s;

    assign ra_s = rd_addr[k*AW +: AW];

    // Address match against every padded write port.
    always_comb begin
      for (int j = 0; j < 4; j++) begin
        rhit_s[j] = wen_s[j] && (waddr_s[j] == ra_s);
      end
    end

    assign rsel_s = wr_match(rhit_s);

    // Bypass mux for this read port.
    always_comb begin
      if (ra_s == {AW{1'b0}}) begin
        rdata_s = {XLEN{1'b0}};
      end else if (rsel_s[2]) begin
        rdata_s = wdata_s[rsel_s[1:0]];
      end else begin
        rdata_s = mem_r[ra_s];
      end
    end

    assign rd_data[k*XLEN +: XLEN] = rdata_s;
    assign rd_busy[k]              = pend_s[ra_s] & ~rsel_s[2];
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .pending   (pend_s),
    .any_busy  (any_busy)
  );

endmodule
